div_unit: RTL and testbench



---
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 143 ++++++++++++++
 tb/tb_div_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: request/response channel bundle for the iterative divider.
//   master (requester): drives req_valid, op, a, b, resp_ready
//   slave  (divider)  : drives req_ready, resp_valid, y, busy
//   op encoding: 0=DIV, 1=DIVU, 2=REM, 3=REMU
interface div_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] y;
   logic                  busy;

   modport master (
      output req_valid, op, a, b, resp_ready,
      input  req_ready, resp_valid, y, busy
   );

   modport slave (
      input  req_valid, op, a, b, resp_ready,
      output req_ready, resp_valid, y, busy
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, MSB first, DATA_WIDTH cycles per operation.
// Signed ops run on magnitudes; the sign fix-up is applied when entering DONE.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset
//   bus  - div_unit_if.slave: req_valid/req_ready/op/a/b request channel,
//          resp_valid/resp_ready/y response channel, busy status
// Build option:
//   DIV_UNIT_FAST_PATH_EN - when defined, divide-by-zero and signed overflow
//   go straight from accept to DONE (1-cycle latency). When undefined, every
//   operation takes the full iteration path and special results override the
//   computed value at the end, so latency is uniform.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// CALC  | iterating, one quotient bit per cycle
// DONE  | y valid, waiting for resp_ready
module div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    dvsr;
   logic [W-1:0]    rem;
   logic [W-1:0]    quo;     // dividend bits shift out as quotient bits shift in
   logic [W-1:0]    y_q;
   logic [W-1:0]    spec_y;
   logic            op_rem, qneg, rneg, special;

   logic            accept, last;
   logic            is_signed, sa, sb, div0, ovf, go_special;
   logic [W-1:0]    a_mag, b_mag, spec_val;
   logic [W:0]      shl;
   logic            ge;
   logic [W-1:0]    rem_nxt, quo_nxt, fix_y;

   assign accept = bus.req_valid && (state == IDLE);
   assign last   = (cnt == CW'(W - 1));

   assign is_signed = ~bus.op[0];
   assign sa        = is_signed & bus.a[W-1];
   assign sb        = is_signed & bus.b[W-1];
   assign a_mag     = sa ? -bus.a : bus.a;
   assign b_mag     = sb ? -bus.b : bus.b;
   assign div0      = (bus.b == '0);
   assign ovf       = is_signed && (bus.a == {1'b1, {(W-1){1'b0}}}) && (bus.b == '1);

   always_comb begin
      spec_val = '0;
      if (div0)
         spec_val = bus.op[1] ? bus.a : '1;
      else if (!bus.op[1])
         spec_val = {1'b1, {(W-1){1'b0}}};
   end

`ifdef DIV_UNIT_FAST_PATH_EN
   assign go_special = div0 | ovf;
`else
   assign go_special = 1'b0;
`endif

   // restoring step: trial-subtract divisor from shifted partial remainder
   assign shl     = {rem, quo[W-1]};
   assign ge      = (shl >= {1'b0, dvsr});
   assign rem_nxt = ge ? (shl[W-1:0] - dvsr) : shl[W-1:0];
   assign quo_nxt = {quo[W-2:0], ge};

   always_comb begin
      fix_y = '0;
      if (op_rem)
         fix_y = rneg ? -rem_nxt : rem_nxt;
      else
         fix_y = qneg ? -quo_nxt : quo_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = go_special ? DONE : CALC;
         CALC: if (last) state_nxt = DONE;
         DONE: if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         dvsr    <= '0;
         rem     <= '0;
         quo     <= '0;
         y_q     <= '0;
         spec_y  <= '0;
         op_rem  <= 1'b0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         special <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               cnt     <= '0;
               rem     <= '0;
               quo     <= a_mag;
               dvsr    <= b_mag;
               op_rem  <= bus.op[1];
               qneg    <= sa ^ sb;
               rneg    <= sa;
               special <= div0 | ovf;
               spec_y  <= spec_val;
               if (go_special) y_q <= spec_val;
            end
            CALC: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt + 1'b1;
               if (last) y_q <= special ? spec_y : fix_y;
            end
            DONE: if (bus.resp_ready) y_q <= '0;
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == DONE);
   assign bus.busy       = (state != IDLE);
   assign bus.y          = y_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   div_unit_if #(.DATA_WIDTH(32)) bus ();

   div_unit #(.DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // RV32M semantics from plain integer arithmetic
   function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] z);
      int sx;
      int sz;
      logic ovf;
      sx  = x;
      sz  = z;
      ovf = (x == 32'h8000_0000) && (z == 32'hFFFF_FFFF);
      case (o)
         2'd0: if (z == 0) return 32'hFFFF_FFFF;
               else if (ovf) return 32'h8000_0000;
               else return 32'(sx / sz);
         2'd1: if (z == 0) return 32'hFFFF_FFFF;
               else return x / z;
         2'd2: if (z == 0) return x;
               else if (ovf) return 32'h0;
               else return 32'(sx % sz);
         default: if (z == 0) return x;
                  else return x % z;
      endcase
   endfunction

   function automatic int exp_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] z);
`ifdef DIV_UNIT_FAST_PATH_EN
      if (z == 0) return 1;
      if (!o[0] && x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 1;
`endif
      return 33;
   endfunction

   // one full transaction; bp>0 holds resp_ready low for bp cycles after resp_valid
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] z, input int bp);
      int lat;
      logic [31:0] exp_y;
      logic [31:0] y0;
      exp_y = ref_model(o, x, z);
      check({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
      bus.op = o; bus.a = x; bus.b = z;
      bus.req_valid  = 1'b1;
      bus.resp_ready = (bp == 0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.a  = $urandom;
      bus.b  = $urandom;
      bus.op = 2'($urandom);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      lat = 1;
      while (!bus.resp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_latency(o, x, z)));
      if (lat >= 100) return;
      check({tag, "_y"}, bus.y, exp_y);
      if (bp > 0) begin
         y0 = bus.y;
         bus.req_valid = 1'b1;
         for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check({tag, "_bp_y"}, bus.y, y0);
            check({tag, "_bp_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "_bp_ready"}, 32'(bus.req_ready), 32'd0);
         end
         bus.req_valid  = 1'b0;
         bus.resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      check({tag, "_post_valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_post_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_post_y"}, bus.y, 32'd0);
   endtask

   initial begin
      int seen;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      bus.op = 2'd0;
      bus.a  = '0;
      bus.b  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_y", bus.y, 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);

      do_op("divu_100_7", 2'd1, 32'd100, 32'd7, 0);
      do_op("remu_100_7", 2'd3, 32'd100, 32'd7, 0);
      do_op("div_m7_2",   2'd0, 32'hFFFF_FFF9, 32'd2, 0);
      do_op("rem_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2, 0);
      do_op("div_7_m2",   2'd0, 32'd7, 32'hFFFF_FFFE, 0);
      do_op("divu_z",     2'd1, 32'd5, 32'd0, 0);
      do_op("div_z",      2'd0, 32'hFFFF_FFFB, 32'd0, 0);
      do_op("rem_z",      2'd2, 32'd5, 32'd0, 0);
      do_op("remu_z",     2'd3, 32'hDEAD_BEEF, 32'd0, 0);
      do_op("div_ovf",    2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op("rem_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op("divu_big",   2'd1, 32'hFFFF_FFFF, 32'd1, 0);
      do_op("bp_divu",    2'd1, 32'd1000, 32'd33, 5);

      // abort in the middle of an operation
      bus.op = 2'd1; bus.a = 32'd1000; bus.b = 32'd3;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ready", 32'(bus.req_ready), 32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_valid", 32'(bus.resp_valid), 32'd0);
      seen = 0;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) seen++;
      end
      bus.resp_ready = 1'b0;
      check("abort_no_resp", 32'(seen), 32'd0);
      do_op("after_abort", 2'd1, 32'd9, 32'd3, 0);

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(1, 15);
            3: ra = $urandom_range(0, 100);
            default: ;
         endcase
         do_op($sformatf("rnd%0d", i), ro, ra, rb,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
